// File: rtl/counter_pkg.sv
// Shared types for the modulo-N up/down counter: terminal-count mode and run state.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RELOAD  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/counter_prescaler.sv
// Step divider: tick is high on every PRESCALE-th cycle in which en is high.
module counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_mod_updown.sv
// Modulo-N up/down counter with load, four terminal-count modes and a registered tc pulse.
// Optional step prescaler compiled in with `define COUNTER_PRESCALE_EN.
module counter_mod_updown
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  logic             up_down,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             running
);

    localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    state_e           state_q, state_d;

    logic qual;
    logic step;
    logic at_term;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_C) ? MAX_C : v;
    endfunction

    assign qual = enable && (state_q == ST_RUN);

`ifdef COUNTER_PRESCALE_EN
    logic tick;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear | load),
        .en   (qual),
        .tick (tick)
    );

    assign step = qual && tick;
`else
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign step            = qual;
`endif

    // Terminal depends on the direction sampled with this step, so reversing moves away without tc.
    assign at_term = up_down ? (count_q == MAX_C) : (count_q == '0);

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        state_d  = state_q;
        tc_d     = 1'b0;
        if (clear) begin
            count_d = '0;
            state_d = ST_RUN;
        end else if (load) begin
            count_d  = clamp_load(data);
            reload_d = clamp_load(data);
            state_d  = ST_RUN;
        end else if (step) begin
            if (!at_term) begin
                count_d = up_down ? count_q + ONE : count_q - ONE;
            end else begin
                tc_d = 1'b1;
                case (mode_e'(mode))
                    MODE_WRAP:    count_d = up_down ? '0 : MAX_C;
                    MODE_SAT:     count_d = count_q;
                    MODE_ONESHOT: state_d = ST_HALT;
                    MODE_RELOAD:  count_d = reload_q;
                    default:      count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            reload_q <= MAX_C;
            tc_q     <= 1'b0;
            state_q  <= ST_RUN;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            state_q  <= state_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: doc/counter_mod_updown.md
# counter_mod_updown

Parametrised modulo-N up/down counter with loadable start value, four terminal-count modes (wrap, saturate, one-shot, auto-reload) and a registered terminal-count pulse. It replaces the plain n-bit up/down counter wherever a non-power-of-two modulus, timer or event-divider behaviour is needed. It is the standard timing/event-count primitive for datapath and control blocks.

## Interface
- WIDTH, 8, counter width in bits
- MAX_VAL, 2**WIDTH-1, top count value; legal range 1 … 2**WIDTH-1
- PRESCALE, 4, step divider ratio; used only when the prescaler is compiled in; legal ≥ 2
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear of count and state
- load  in  1  load `data` into count and reload register
- data  in  WIDTH  load value
- enable  in  1  step request
- up_down  in  1  1 = count up, 0 = count down
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 auto-reload
- count  out  WIDTH  current count (registered)
- tc  out  1  terminal-count pulse (registered, 1 cycle)
- running  out  1  counter accepts steps

## Operation
- Reset values: count = 0, reload register = MAX_VAL, tc = 0, running = 1, prescaler = 0.
- Priority per edge: rst > clear > load > step.
- clear: count ← 0, running ← 1, tc ← 0, prescaler ← 0; reload register unchanged.
- load: value = min(data, MAX_VAL); count ← value, reload register ← value, running ← 1, prescaler ← 0, tc ← 0.
- Step occurs when enable & running (and the prescaler tick, if compiled in).
- Terminal: up → count == MAX_VAL; down → count == 0.
- Step not at terminal: count ± 1. Arithmetic is WIDTH bits; no intermediate value exceeds MAX_VAL.
- Step at terminal, by mode:
  - 00 wrap: up → 0, down → MAX_VAL.
  - 01 saturate: count holds.
  - 10 one-shot: count holds, running ← 0.
  - 11 auto-reload: count ← reload register, in either direction.
  - tc ← 1 in all four modes.
- Without a step at terminal, tc ← 0.
- State machine, 2 states:
  - RUN (running = 1) → HALT on a one-shot terminal step.
  - HALT (running = 0) → RUN on load, clear or rst. enable is ignored in HALT.
- A mode change takes effect on the next step. A change while in HALT does not restart the counter.
- up_down is sampled per step. Reversing direction at a terminal value moves away from it without asserting tc.

## Timing
- count updates on the clk edge that samples the step, load or clear; latency is 1 cycle.
- tc is high for exactly the cycle following a terminal step edge. Back-to-back terminal steps (saturate mode) keep tc high continuously.
- running falls on the same edge that asserts tc in one-shot mode.
- rst asserted mid-operation forces all outputs to their reset values immediately. Release is synchronised externally; this block does not synchronise the rst deassertion.

## Configuration
- COUNTER_PRESCALE_EN defined: a step needs enable & running & tick.
  - tick pulses once every PRESCALE cycles in which enable & running is high. The first step occurs on the PRESCALE-th qualifying cycle.
  - The prescaler holds while enable is low and resets on rst, clear or load.
- Not defined: no prescaler logic; every enable & running cycle steps. PRESCALE is ignored.

## Structure
- Shared package counter_pkg: 2-bit mode enum (MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RELOAD) and the RUN/HALT state encoding.
- One sub-module, counter_prescaler (parameter PRESCALE; inputs clk, rst, clr, en; output tick). It is instantiated only under COUNTER_PRESCALE_EN.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9, prescaler off.
- Wrap up: mode 00, up, enable held from 0 → count 1…9, then 0; tc high for exactly the cycle after the 9→0 edge.
- Wrap down plus direction reversal: load 0, down, step → count 9 with tc. Then up from 9 → 0 with tc. Then 0, down → 9.
- Saturate: mode 01, load 8, up, enable 3 cycles → count 9, 9, 9; tc low, high, high. A load of 15 clamps count to 9.
- One-shot: mode 10, load 3, down, enable held → 2, 1, 0, then hold. tc pulses once and running falls. Further enable leaves count at 0; load 5 restores running = 1.
- Auto-reload and priority: mode 11, load 4, down → 3, 2, 1, 0, then 4 with tc. Simultaneous clear+load → count 0. rst mid-count → count 0, tc 0, running 1 with no clock edge.
- With COUNTER_PRESCALE_EN and PRESCALE=3: enable held → count advances every 3rd cycle. A load mid-period restarts the 3-cycle phase.
